stream_wrr_scheduler: RTL and testbench

Packet-aware weighted round-robin scheduler that shares one AXI-Stream-style output channel between `INPUT_NUM` requesters. Once granted, an input owns the output until the beat flagged `last_i` completes, so bursts are never interleaved. Each input may send up to its programmed weight in consecutive packets before the grant rotates. It sits in front of NoC router output ports and feeds a single downstream channel (W or R data path).

---
 rtl/stream_wrr_scheduler.sv | 148 ++++++++++++++
 tb/tb_stream_wrr_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// stream_wrr_scheduler: packet-locked weighted round-robin arbiter, one stream out.
// Option STREAM_WRR_SCHEDULER_PMU_EN adds per-input packet counters (pkt_cnt_o).
// Revision: 1.0
// ============================================================================
module stream_wrr_scheduler #(
    parameter int INPUT_NUM    = 5,
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [INPUT_NUM*DATA_WIDTH-1:0]   data_i,
    input  logic [INPUT_NUM-1:0]              valid_i,
    input  logic [INPUT_NUM-1:0]              last_i,
    output logic [INPUT_NUM-1:0]              ready_o,
    input  logic [INPUT_NUM*WEIGHT_WIDTH-1:0] weight_i,
    output logic [DATA_WIDTH-1:0]             data_o,
    output logic                              valid_o,
    output logic                              last_o,
    input  logic                              ready_i,
    output logic [INPUT_NUM-1:0]              grant_o
`ifdef STREAM_WRR_SCHEDULER_PMU_EN
    ,
    output logic [INPUT_NUM*32-1:0]           pkt_cnt_o
`endif
);

    localparam int PTR_W = $clog2(INPUT_NUM);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    has_prev_q, has_prev_d;
    logic                    regrant_q, regrant_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

    logic                    w_found;
    logic [PTR_W-1:0]        w_idx;
    logic [PTR_W-1:0]        w_pick;
    logic [WEIGHT_WIDTH-1:0] w_weight;
    logic                    w_done;

    // First valid input at or after ptr, wrapping modulo INPUT_NUM.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < INPUT_NUM; i++) begin
            w_idx = PTR_W'((int'(ptr_q) + i) % INPUT_NUM);
            if (!w_found && valid_i[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_weight = weight_i[w_pick*WEIGHT_WIDTH +: WEIGHT_WIDTH];

    always_comb begin
        data_o  = '0;
        valid_o = 1'b0;
        last_o  = 1'b0;
        ready_o = '0;
        grant_o = '0;
        if (state_q == ST_LOCKED) begin
            data_o           = data_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
            valid_o          = valid_i[owner_q];
            last_o           = last_i[owner_q];
            ready_o[owner_q] = ready_i;
            grant_o[owner_q] = 1'b1;
        end
    end

    assign w_done = (state_q == ST_LOCKED) && valid_o && ready_i && last_o;

    // credit holds the re-grants still owed; only re-granted packets consume it,
    // so a weight of W yields W consecutive packets.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        has_prev_d = has_prev_q;
        regrant_d  = regrant_q;
        credit_d   = credit_q;
        if (state_q == ST_IDLE) begin
            if (|valid_i) begin
                state_d    = ST_LOCKED;
                has_prev_d = 1'b1;
                if (has_prev_q && (credit_q != '0) && valid_i[owner_q]) begin
                    regrant_d = 1'b1;
                end else begin
                    owner_d   = w_pick;
                    regrant_d = 1'b0;
                    credit_d  = (w_weight == '0) ? '0 : w_weight - WEIGHT_WIDTH'(1);
                    ptr_d     = (w_pick == PTR_W'(INPUT_NUM - 1)) ? '0 : w_pick + PTR_W'(1);
                end
            end
        end else if (w_done) begin
            state_d = ST_IDLE;
            if (regrant_q && (credit_q != '0)) begin
                credit_d = credit_q - WEIGHT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            has_prev_q <= 1'b0;
            regrant_q  <= 1'b0;
            credit_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            has_prev_q <= has_prev_d;
            regrant_q  <= regrant_d;
            credit_q   <= credit_d;
        end
    end

`ifdef STREAM_WRR_SCHEDULER_PMU_EN
    generate
        for (genvar g = 0; g < INPUT_NUM; g++) begin : g_pkt_cnt
            logic [31:0] cnt_q;
            always_ff @(posedge ACLK) begin
                if (!ARESETn) begin
                    cnt_q <= '0;
                end else if (w_done && (owner_q == PTR_W'(g))) begin
                    cnt_q <= cnt_q + 32'd1;
                end
            end
            assign pkt_cnt_o[g*32 +: 32] = cnt_q;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_stream_wrr_scheduler: randomized scoreboard bench with a packet-level WRR model.
// Revision: 1.0
// ============================================================================
module tb_stream_wrr_scheduler;
    localparam int N  = 5;
    localparam int DW = 16;
    localparam int WW = 4;

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]    valid_i, last_i, ready_o, grant_o;
    logic [N*WW-1:0] weight_i;
    logic [DW-1:0]   data_o;
    logic            valid_o, last_o, ready_i;
`ifdef STREAM_WRR_SCHEDULER_PMU_EN
    logic [N*32-1:0] pkt_cnt_o;
`endif

    stream_wrr_scheduler #(.INPUT_NUM(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .data_i(data_i), .valid_i(valid_i),
        .last_i(last_i), .ready_o(ready_o), .weight_i(weight_i), .data_o(data_o),
        .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i), .grant_o(grant_o)
`ifdef STREAM_WRR_SCHEDULER_PMU_EN
        , .pkt_cnt_o(pkt_cnt_o)
`endif
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int            owner;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    logic [DW:0] inq [N][$];     // per-input pending beats {last,data}
    beat_t       expq[$];        // scoreboard of beats expected on the output
    beat_t       mb;
    logic [DW:0] h;

    // packet-level model: lock owner, turns left for the owner, rotation pointer
    bit          m_lock, n_lock, n_done, pend_rst, mon_en;
    int          m_owner, m_prev, m_left, m_ptr;
    int          n_owner, n_prev, n_left, n_ptr;
    int          m_cnt[N];
    int          acc[N];
    logic [N-1:0] pend_hs, eg;
    int          win, wv, kk;
    int          rst_cnt;
    bit          rdy_rand, gap_en, wrand;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_owner = 0; m_prev = -1; m_left = 0; m_ptr = 0;
        n_lock = 0; n_owner = 0; n_prev = -1; n_left = 0; n_ptr = 0; n_done = 0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endtask

    task automatic add_pkt(int k, int len);
        for (int b = 0; b < len; b++)
            inq[k].push_back({(b == len - 1), DW'($urandom)});
    endtask

    function automatic bit any_pending();
        for (int k = 0; k < N; k++) if (inq[k].size() != 0) return 1;
        return 0;
    endfunction

    // one clock: apply last edge's effects, drive new inputs, predict next edge
    task automatic cycle();
        @(negedge ACLK);
        if (pend_rst) begin
            model_reset();
            for (int k = 0; k < N; k++) inq[k].delete();
            expq.delete();
        end else begin
            for (int k = 0; k < N; k++)
                if (pend_hs[k] && inq[k].size() != 0) begin
                    void'(inq[k].pop_front());
                    acc[k]++;
                end
            if (n_done) m_cnt[m_owner]++;
            m_lock = n_lock; m_owner = n_owner; m_prev = n_prev;
            m_left = n_left; m_ptr = n_ptr;
        end
        ARESETn = (rst_cnt == 0);
        if (rst_cnt > 0) rst_cnt--;
        ready_i = !ARESETn ? 1'b0 : (rdy_rand ? ($urandom_range(2) != 0) : 1'b1);
        if (wrand && $urandom_range(7) == 0)
            for (int k = 0; k < N; k++) weight_i[k*WW +: WW] = WW'($urandom_range(4));
        for (int k = 0; k < N; k++) begin
            if (inq[k].size() != 0 && (!gap_en || $urandom_range(3) != 0)) begin
                h = inq[k][0];
                valid_i[k]          = 1'b1;
                data_i[k*DW +: DW]  = h[DW-1:0];
                last_i[k]           = h[DW];
            end else begin
                valid_i[k]          = 1'b0;
                data_i[k*DW +: DW]  = DW'($urandom);
                last_i[k]           = 1'($urandom_range(1));
            end
        end
        #1;
        pend_rst = !ARESETn;
        pend_hs  = valid_i & ready_o;
        n_done = 0;
        n_lock = m_lock; n_owner = m_owner; n_prev = m_prev; n_left = m_left; n_ptr = m_ptr;
        if (!ARESETn) begin
            n_lock = 0;
        end else if (!m_lock) begin
            if (valid_i != '0) begin
                win = -1;
                if (m_prev >= 0 && m_left > 0 && valid_i[m_prev]) begin
                    win    = m_prev;
                    n_left = m_left - 1;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        kk = (m_ptr + i) % N;
                        if (win < 0 && valid_i[kk]) win = kk;
                    end
                    wv     = int'(weight_i[win*WW +: WW]);
                    n_left = ((wv == 0) ? 1 : wv) - 1;
                    n_ptr  = (win + 1) % N;
                end
                n_lock = 1; n_owner = win; n_prev = win;
                for (int j = 0; j < inq[win].size(); j++) begin
                    h = inq[win][j];
                    expq.push_back('{win, h[DW], h[DW-1:0]});
                    if (h[DW]) break;
                end
            end
        end else if (valid_i[m_owner] && ready_i && last_i[m_owner]) begin
            n_lock = 0;
            n_done = 1;
        end
    endtask

    task automatic drain(int maxc);
        int c;
        c = 0;
        while ((any_pending() || m_lock || n_lock) && c < maxc) begin
            cycle();
            c++;
        end
        check("drain_timeout", 64'(c >= maxc), 64'(0));
        cycle();
        check("scoreboard_empty", 64'(expq.size()), 64'(0));
    endtask

    task automatic reset_pulse();
        rst_cnt = 1;
        cycle();
        cycle();
    endtask

    // monitor: compares DUT outputs against the model's view of this cycle
    always @(negedge ACLK) begin
        #2;
        if (mon_en) begin
            eg = m_lock ? (N'(1) << m_owner) : '0;
            check("grant", 64'(grant_o), 64'(eg));
            check("ready", 64'(ready_o), 64'(ready_i ? eg : '0));
            if (!m_lock)
                check("idle_out", 64'({valid_o, last_o, data_o}), 64'(0));
            else
                check("valid", 64'(valid_o), 64'(valid_i[m_owner]));
            if (valid_o && ready_i) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected actual=%0h required=none t=%0t", data_o, $time);
                end else begin
                    mb = expq.pop_front();
                    check("beat", 64'({grant_o, last_o, data_o}),
                          64'({N'(1) << mb.owner, mb.last, mb.data}));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        ARESETn = 1'b0; valid_i = '0; last_i = '0; data_i = '0; ready_i = 1'b0;
        weight_i = {N{WW'(1)}};
        rst_cnt = 3; rdy_rand = 0; gap_en = 0; wrand = 0; mon_en = 0;
        pend_rst = 0; pend_hs = '0;
        for (int k = 0; k < N; k++) acc[k] = 0;
        model_reset();
        repeat (2) cycle();
        mon_en = 1;
        repeat (3) cycle();
        check("reset_state", 64'({grant_o, ready_o, valid_o, last_o, data_o}), 64'(0));

        // single requester, 3-beat packet
        add_pkt(2, 3);
        drain(50);

        // all five valid, single-beat packets, equal weights
        reset_pulse();
        for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) add_pkt(k, 1);
        drain(100);

        // weights {3,1,1,1,1}, inputs 0 and 1 continuously requesting
        weight_i = {WW'(1), WW'(1), WW'(1), WW'(1), WW'(3)};
        reset_pulse();
        for (int r = 0; r < 12; r++) begin add_pkt(0, 1); add_pkt(1, 1); end
        drain(200);

        // lock integrity: input 0 arrives while input 2 is mid-packet
        weight_i = {N{WW'(1)}};
        rdy_rand = 1;
        add_pkt(2, 6);
        repeat (2) cycle();
        add_pkt(0, 2);
        drain(200);

        // randomized traffic, stalls, valid gaps and weight changes
        gap_en = 1; wrand = 1;
        for (int r = 0; r < 60; r++) begin
            add_pkt($urandom_range(N - 1), $urandom_range(1, 4));
            repeat ($urandom_range(3)) cycle();
        end
        drain(3000);
        rdy_rand = 0; gap_en = 0; wrand = 0;
        weight_i = {N{WW'(1)}};

        // reset after the 2nd of 4 beats, then all inputs request
        reset_pulse();
        begin
            int a0, c;
            a0 = acc[2];
            c  = 0;
            add_pkt(2, 4);
            cycle();
            while (!(acc[2] == a0 + 1 && pend_hs[2]) && c < 50) begin
                cycle();
                c++;
            end
            check("reset_wait_timeout", 64'(c >= 50), 64'(0));
        end
        rst_cnt = 1;
        cycle();
        cycle();
        check("mid_reset_out", 64'({grant_o, ready_o, valid_o, last_o, data_o}), 64'(0));
        for (int k = 0; k < N; k++) add_pkt(k, 2);
        drain(200);

`ifdef STREAM_WRR_SCHEDULER_PMU_EN
        reset_pulse();
        for (int r = 0; r < 7; r++) add_pkt(3, $urandom_range(1, 3));
        drain(200);
        for (int k = 0; k < N; k++)
            check("pkt_cnt", 64'(pkt_cnt_o[k*32 +: 32]), 64'(m_cnt[k]));
        check("pkt_cnt3_seven", 64'(pkt_cnt_o[3*32 +: 32]), 64'(7));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
